// File: rtl/i2c_slave_ctrl.sv
// Control FSM of the I2C slave transmitter: address receive, ACK/NACK, byte load/transmit
// and master-ACK sampling. Every output is registered and reflects the state being entered.
module i2c_slave_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       scl_rise,
    input  logic       scl_fall,
    input  logic [7:0] rx_data,
    input  logic       sda_in,
    input  logic       fifo_empty,
    output logic [1:0] sda_mode,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic       read_enable,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_CHK       = 4'd2,
        S_ACK_A     = 4'd3,
        S_NACK_A    = 4'd4,
        S_LOAD      = 4'd5,
        S_TX_BYTE   = 4'd6,
        S_M_ACK     = 4'd7,
        S_WAIT_STOP = 4'd8
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] bit_cnt_r;
    logic       ack_bit_r;
    logic       clr_cnt_s;

    function automatic logic [1:0] mode_of(input state_t st);
        case (st)
            S_ACK_A:   mode_of = 2'b01;
            S_NACK_A:  mode_of = 2'b10;
            S_M_ACK:   mode_of = 2'b10;
            S_LOAD:    mode_of = 2'b11;
            S_TX_BYTE: mode_of = 2'b11;
            default:   mode_of = 2'b00;
        endcase
    endfunction

    // Next-state decode: STOP beats START beats the per-state transitions.
    always_comb begin
        next_state_s = S_IDLE;
        if (stop_found) begin
            next_state_s = S_IDLE;
        end else if (start_found) begin
            next_state_s = S_ADDR;
        end else begin
            case (state_r)
                S_IDLE:      next_state_s = S_IDLE;
                S_ADDR: begin
                    if (bit_cnt_r == 4'd8 && scl_fall) next_state_s = S_CHK;
                    else                               next_state_s = S_ADDR;
                end
                S_CHK: begin
                    if (rx_data[7:1] != SLAVE_ADDR) next_state_s = S_WAIT_STOP;
                    else if (rx_data[0])            next_state_s = S_ACK_A;
                    else                            next_state_s = S_NACK_A;
                end
                S_ACK_A: begin
                    if (scl_fall) next_state_s = S_LOAD;
                    else          next_state_s = S_ACK_A;
                end
                S_NACK_A: begin
                    if (scl_fall) next_state_s = S_WAIT_STOP;
                    else          next_state_s = S_NACK_A;
                end
                S_LOAD:      next_state_s = S_TX_BYTE;
                S_TX_BYTE: begin
                    if (bit_cnt_r == 4'd8 && scl_fall) next_state_s = S_M_ACK;
                    else                               next_state_s = S_TX_BYTE;
                end
                S_M_ACK: begin
                    if (scl_fall && !ack_bit_r)     next_state_s = S_LOAD;
                    else if (scl_fall && ack_bit_r) next_state_s = S_WAIT_STOP;
                    else                            next_state_s = S_M_ACK;
                end
                S_WAIT_STOP: next_state_s = S_WAIT_STOP;
                default:     next_state_s = S_IDLE;
            endcase
        end
    end

    // Counter is cleared whenever ADDR (incl. repeated START) or TX_BYTE is entered.
    always_comb begin
        clr_cnt_s = 1'b0;
        if ((!stop_found && start_found) || (state_r == S_LOAD && next_state_s == S_TX_BYTE)) begin
            clr_cnt_s = 1'b1;
        end else begin
            clr_cnt_s = 1'b0;
        end
    end

    // State, bit counter, master-ACK capture and registered output decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            bit_cnt_r   <= 4'd0;
            ack_bit_r   <= 1'b1;
            sda_mode    <= 2'b00;
            rx_enable   <= 1'b0;
            tx_enable   <= 1'b0;
            load_data   <= 1'b0;
            read_enable <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r <= next_state_s;

            if (clr_cnt_s)
                bit_cnt_r <= 4'd0;
            else if (scl_rise && bit_cnt_r != 4'd8)
                bit_cnt_r <= bit_cnt_r + 4'd1;

            // Default to NACK so a missing sample never requests another byte.
            if (state_r == S_M_ACK && scl_rise)
                ack_bit_r <= sda_in;
            else if (state_r != S_M_ACK && next_state_s == S_M_ACK)
                ack_bit_r <= 1'b1;

            sda_mode    <= mode_of(next_state_s);
            rx_enable   <= (next_state_s == S_ADDR);
            tx_enable   <= (next_state_s == S_TX_BYTE);
            load_data   <= (next_state_s == S_LOAD);
            read_enable <= (next_state_s == S_LOAD) && !fifo_empty;
            busy        <= (next_state_s != S_IDLE);
        end
    end

endmodule
